// File: rtl/ms_pkg.sv
// Shared constants for the 5x5 minesweeper board: mine layout, neighbour counts
// and geometry helpers used by the board engine and its wrapper.
package ms_pkg;

  localparam int N       = 5;
  localparam int CELLS   = N * N;
  localparam int CELL_PX = 32;
  localparam int ID_W    = 5;

  typedef logic [CELLS-1:0] cell_mask_t;
  typedef logic [ID_W-1:0]  cell_id_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_OVER
  } ms_state_e;

  // Mines sit on cells 1, 7, 13, 19 and 22.
  localparam cell_mask_t MINE_MASK = (cell_mask_t'(1) << 1)
                                   | (cell_mask_t'(1) << 7)
                                   | (cell_mask_t'(1) << 13)
                                   | (cell_mask_t'(1) << 19)
                                   | (cell_mask_t'(1) << 22);

  // Entry i is the 8-neighbour mine count of cell i; mine cells hold 0.
  localparam logic [CELLS-1:0][3:0] COUNT_TABLE = {
    4'd1, 4'd2, 4'd0, 4'd1, 4'd0,
    4'd0, 4'd3, 4'd2, 4'd1, 4'd0,
    4'd2, 4'd0, 4'd2, 4'd1, 4'd0,
    4'd1, 4'd2, 4'd0, 4'd2, 4'd1,
    4'd0, 4'd1, 4'd2, 4'd0, 4'd1
  };

  localparam cell_mask_t ZERO_MASK = (cell_mask_t'(1) << 4)
                                   | (cell_mask_t'(1) << 10)
                                   | (cell_mask_t'(1) << 15)
                                   | (cell_mask_t'(1) << 20);

  function automatic int cell_row(input int id);
    return id / N;
  endfunction

  function automatic int cell_col(input int id);
    return id % N;
  endfunction

  function automatic cell_mask_t neighbour_mask(input int id);
    cell_mask_t m;
    int r;
    int c;
    m = '0;
    r = cell_row(id);
    c = cell_col(id);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) &&
            (r + dr) >= 0 && (r + dr) < N &&
            (c + dc) >= 0 && (c + dc) < N) begin
          m[(r + dr) * N + (c + dc)] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  // Union of the neighbourhoods of every set cell in src.
  function automatic cell_mask_t spread(input cell_mask_t src);
    cell_mask_t acc;
    acc = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (src[i]) begin
        acc = acc | neighbour_mask(i);
      end
    end
    return acc;
  endfunction

  function automatic cell_mask_t cell_bit(input cell_id_t id);
    return cell_mask_t'(1) << id;
  endfunction

endpackage

// File: rtl/wrapper_if.sv
// Front-end/renderer bundle for the board engine: flip request and board origin in,
// revealed mask, status and highlight position out.
interface wrapper_if;
  import ms_pkg::*;

  logic [9:0]       x_topleft;
  logic [8:0]       y_topleft;
  logic             flip;
  logic [31:0]      VGAid;
  logic [CELLS-1:0] revealed;
  logic             game_over;
  logic             win;
  logic             busy;
  logic [ID_W-1:0]  last_id;
  logic [9:0]       hl_x;
  logic [8:0]       hl_y;

  modport master (
    output x_topleft, y_topleft, flip, VGAid,
    input  revealed, game_over, win, busy, last_id, hl_x, hl_y
  );

  modport slave (
    input  x_topleft, y_topleft, flip, VGAid,
    output revealed, game_over, win, busy, last_id, hl_x, hl_y
  );

endinterface

// File: rtl/ms_board_state.sv
// Revealed-cell register with the game FSM: applies accepted flips, runs the
// zero-region flood fill one ring per cycle, and derives win/over status.
module ms_board_state
  import ms_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       accept,
  input  cell_id_t   accept_id,
  output cell_mask_t revealed,
  output logic       busy,
  output logic       game_over,
  output logic       win
);

  ms_state_e  state;
  ms_state_e  state_nxt;
  cell_mask_t revealed_nxt;
  cell_mask_t fill_set;
  cell_mask_t flip_bit;
  logic       flip_is_mine;
  logic       flip_is_zero;

  always_comb begin
    flip_bit     = cell_bit(accept_id);
    flip_is_mine = |(flip_bit & MINE_MASK);
    flip_is_zero = |(flip_bit & ZERO_MASK);
    fill_set     = spread(revealed & ZERO_MASK & ~MINE_MASK);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      revealed <= '0;
    end else begin
      state    <= state_nxt;
      revealed <= revealed_nxt;
    end
  end

  // FILL keeps going until a step adds nothing; that final step still counts as busy.
  always_comb begin
    state_nxt    = state;
    revealed_nxt = revealed;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          revealed_nxt = revealed | flip_bit;
          if (flip_is_mine) begin
            state_nxt = ST_OVER;
          end else if (flip_is_zero) begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        revealed_nxt = revealed | fill_set;
        if (revealed_nxt == revealed) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_OVER: begin
        state_nxt = ST_OVER;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state == ST_FILL);
    game_over = (state == ST_OVER);
    win       = (&(revealed | MINE_MASK)) && !game_over;
  end

endmodule

// File: rtl/wrapper.sv
// Board engine top: detects flip edges, gates them against busy/over/win and
// range, and tracks the id and pixel origin of the last accepted cell.
module wrapper #(
  parameter int CELL_PX = 32,
  parameter int N       = 5
) (
  input logic      clock,
  input logic      reset,
  wrapper_if.slave bus
);
  import ms_pkg::*;

  logic       flip_q;
  logic       flip_edge;
  logic       accept;
  cell_id_t   cell_id;
  cell_id_t   last_id;
  logic [9:0] hl_x;
  logic [8:0] hl_y;
  logic [9:0] px_x;
  logic [8:0] px_y;
  int         row;
  int         col;
  cell_mask_t revealed;
  logic       busy;
  logic       game_over;
  logic       win;

  // Out-of-range ids are rejected on the full 32-bit value, not the truncated one.
  always_comb begin
    cell_id   = bus.VGAid[ID_W-1:0];
    flip_edge = bus.flip && !flip_q;
    accept    = flip_edge && !busy && !game_over && !win &&
                (bus.VGAid < 32'(CELLS));
  end

  always_comb begin
    row  = int'(cell_id) / N;
    col  = int'(cell_id) % N;
    px_x = bus.x_topleft + 10'(col * CELL_PX);
    px_y = bus.y_topleft + 9'(row * CELL_PX);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flip_q  <= 1'b0;
      last_id <= '0;
      hl_x    <= '0;
      hl_y    <= '0;
    end else begin
      flip_q <= bus.flip;
      if (accept) begin
        last_id <= cell_id;
        hl_x    <= px_x;
        hl_y    <= px_y;
      end
    end
  end

  ms_board_state u_board (
    .clock     (clock),
    .reset     (reset),
    .accept    (accept),
    .accept_id (cell_id),
    .revealed  (revealed),
    .busy      (busy),
    .game_over (game_over),
    .win       (win)
  );

  assign bus.revealed  = revealed;
  assign bus.busy      = busy;
  assign bus.game_over = game_over;
  assign bus.win       = win;
  assign bus.last_id   = last_id;
  assign bus.hl_x      = hl_x;
  assign bus.hl_y      = hl_y;

endmodule

// File: tb/tb_wrapper.sv
// Self-checking bench for the minesweeper board engine: directed vector table,
// hand-written multi-cycle corner cases and random flips against a flood-fill model.
module tb_wrapper;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  wrapper_if bus ();

  wrapper #(.CELL_PX(32), .N(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  bit [24:0] m_rev;
  bit        m_over;
  bit [4:0]  m_last;
  bit [9:0]  m_hx;
  bit [8:0]  m_hy;

  typedef struct {
    logic [31:0] id;
    logic [24:0] exp_rev;
    int          exp_last;
    logic [9:0]  exp_hx;
    logic [8:0]  exp_hy;
    bit          exp_over;
  } vec_t;

  vec_t vecs[5];

  function automatic bit is_mine(input int id);
    return id == 1 || id == 7 || id == 13 || id == 19 || id == 22;
  endfunction

  function automatic int mine_count(input int id);
    int n;
    int r;
    int c;
    n = 0;
    r = id / 5;
    c = id % 5;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 5 &&
            c + dc >= 0 && c + dc < 5 && is_mine((r + dr) * 5 + c + dc))
          n++;
    return n;
  endfunction

  function automatic bit model_win();
    bit all;
    all = 1'b1;
    for (int i = 0; i < 25; i++)
      if (!is_mine(i) && !m_rev[i]) all = 1'b0;
    return all && !m_over;
  endfunction

  task automatic model_reset();
    m_rev  = '0;
    m_over = 1'b0;
    m_last = '0;
    m_hx   = '0;
    m_hy   = '0;
  endtask

  // Breadth-first flood from the flipped cell through zero-count cells.
  task automatic model_flip(input logic [31:0] vga, input logic [9:0] x,
                            input logic [8:0] y, output bit fills);
    int q[$];
    int id;
    int cur;
    fills = 1'b0;
    if (m_over || model_win() || vga >= 32'd25) return;
    id     = int'(vga);
    m_last = 5'(id);
    m_hx   = 10'(int'(x) + (id % 5) * 32);
    m_hy   = 9'(int'(y) + (id / 5) * 32);
    m_rev[id] = 1'b1;
    if (is_mine(id)) begin
      m_over = 1'b1;
    end else if (mine_count(id) == 0) begin
      fills = 1'b1;
      q.push_back(id);
      while (q.size() > 0) begin
        cur = q.pop_front();
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int r;
            int c;
            int nb;
            r = cur / 5 + dr;
            c = cur % 5 + dc;
            if ((dr != 0 || dc != 0) && r >= 0 && r < 5 && c >= 0 && c < 5) begin
              nb = r * 5 + c;
              if (!m_rev[nb]) begin
                m_rev[nb] = 1'b1;
                if (!is_mine(nb) && mine_count(nb) == 0) q.push_back(nb);
              end
            end
          end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_revealed"},  32'(bus.revealed),  32'(m_rev));
    checkOutput({tag, "_last_id"},   32'(bus.last_id),   32'(m_last));
    checkOutput({tag, "_hl_x"},      32'(bus.hl_x),      32'(m_hx));
    checkOutput({tag, "_hl_y"},      32'(bus.hl_y),      32'(m_hy));
    checkOutput({tag, "_game_over"}, 32'(bus.game_over), 32'(m_over));
    checkOutput({tag, "_win"},       32'(bus.win),       32'(model_win()));
  endtask

  task automatic wait_idle(input bit expect_fill);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (expect_fill)
      checkOutput("fill_cycles_in_range", 32'(n >= 1 && n <= 25), 32'd1);
    checkOutput("busy_cleared", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b0;
    bus.flip = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic applyStimulus(input logic [31:0] vga, input logic [9:0] x,
                               input logic [8:0] y);
    bit fills;
    @(negedge clock);
    bus.VGAid     = vga;
    bus.x_topleft = x;
    bus.y_topleft = y;
    bus.flip      = 1'b1;
    model_flip(vga, x, y, fills);
    @(posedge clock);
    #1;
    checkOutput("busy_after_flip", 32'(bus.busy), 32'(fills));
    @(negedge clock);
    bus.flip = 1'b0;
    wait_idle(fills);
  endtask

  initial begin
    bit fills;

    reset         = 1'b0;
    bus.flip      = 1'b0;
    bus.VGAid     = '0;
    bus.x_topleft = '0;
    bus.y_topleft = '0;
    model_reset();

    // Expected masks: 0x318C60 = {5,6,10,11,15,16,20,21}; +8 -> 0x318D60; +1 -> 0x318D62.
    vecs[0] = '{32'd10, 25'h318C60, 10, 10'd5,   9'd67,  1'b0};
    vecs[1] = '{32'd8,  25'h318D60, 8,  10'd101, 9'd35,  1'b0};
    vecs[2] = '{32'd20, 25'h318D60, 20, 10'd5,   9'd131, 1'b0};
    vecs[3] = '{32'd1,  25'h318D62, 1,  10'd37,  9'd3,   1'b1};
    vecs[4] = '{32'd15, 25'h318D62, 1,  10'd37,  9'd3,   1'b1};

    do_reset();
    #1;
    checkOutput("reset_revealed",  32'(bus.revealed),  32'd0);
    checkOutput("reset_game_over", 32'(bus.game_over), 32'd0);
    checkOutput("reset_win",       32'(bus.win),       32'd0);
    checkOutput("reset_busy",      32'(bus.busy),      32'd0);
    checkOutput("reset_last_id",   32'(bus.last_id),   32'd0);
    checkOutput("reset_hl_x",      32'(bus.hl_x),      32'd0);
    checkOutput("reset_hl_y",      32'(bus.hl_y),      32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].id, 10'd5, 9'd3);
      checkOutput($sformatf("vec%0d_revealed", i), 32'(bus.revealed), 32'(vecs[i].exp_rev));
      checkOutput($sformatf("vec%0d_last_id", i),  32'(bus.last_id),  32'(vecs[i].exp_last));
      checkOutput($sformatf("vec%0d_hl_x", i),     32'(bus.hl_x),     32'(vecs[i].exp_hx));
      checkOutput($sformatf("vec%0d_hl_y", i),     32'(bus.hl_y),     32'(vecs[i].exp_hy));
      checkOutput($sformatf("vec%0d_over", i),     32'(bus.game_over), 32'(vecs[i].exp_over));
    end

    do_reset();
    applyStimulus(32'd4, 10'd5, 9'd3);
    checkOutput("flip4_revealed", 32'(bus.revealed), 32'h318);
    applyStimulus(32'd40, 10'd5, 9'd3);
    checkOutput("oob_revealed", 32'(bus.revealed), 32'h318);
    checkOutput("oob_last_id",  32'(bus.last_id),  32'd4);

    // Held flip: the id changes mid-hold, so a second action would reveal cell 2.
    @(negedge clock);
    bus.VGAid = 32'd0;
    bus.flip  = 1'b1;
    model_flip(32'd0, 10'd5, 9'd3, fills);
    @(posedge clock);
    #1;
    checkOutput("hold_first", 32'(bus.revealed), 32'h319);
    @(negedge clock);
    bus.VGAid = 32'd2;
    repeat (49) @(negedge clock);
    bus.flip = 1'b0;
    wait_idle(1'b0);
    checkOutput("hold_single_action", 32'(bus.revealed), 32'h319);
    checkOutput("hold_last_id",       32'(bus.last_id),  32'd0);

    @(negedge clock);
    bus.VGAid = 32'd10;
    bus.flip  = 1'b1;
    model_flip(32'd10, 10'd5, 9'd3, fills);
    @(posedge clock);
    #1;
    checkOutput("drop_busy_high", 32'(bus.busy), 32'd1);
    @(negedge clock);
    bus.flip = 1'b0;
    @(negedge clock);
    bus.VGAid = 32'd2;
    bus.flip  = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("drop_bit2_clear", 32'(bus.revealed[2]), 32'd0);
    @(negedge clock);
    bus.flip = 1'b0;
    wait_idle(1'b1);
    checkModel("after_drop");

    for (int i = 0; i < 25; i++)
      if (!is_mine(i)) applyStimulus(32'(i), 10'd5, 9'd3);
    checkOutput("win_set",  32'(bus.win),       32'd1);
    checkModel("win_state");
    applyStimulus(32'd1, 10'd5, 9'd3);
    checkOutput("win_blocks_mine", 32'(bus.game_over), 32'd0);
    checkModel("after_win_flip");

    do_reset();
    @(negedge clock);
    bus.VGAid = 32'd10;
    bus.flip  = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("midfill_busy", 32'(bus.busy), 32'd1);
    @(negedge clock);
    bus.flip = 1'b0;
    reset    = 1'b0;
    #1;
    checkOutput("midfill_revealed_clear", 32'(bus.revealed), 32'd0);
    checkOutput("midfill_busy_clear",     32'(bus.busy),     32'd0);
    checkOutput("midfill_last_id_clear",  32'(bus.last_id),  32'd0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("midfill_no_resume_rev",  32'(bus.revealed), 32'd0);
    checkOutput("midfill_no_resume_busy", 32'(bus.busy),     32'd0);

    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int k = 0; k < 20; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 7))
          0:       v = $urandom;
          1:       v = 32'($urandom_range(25, 31));
          default: v = 32'($urandom_range(0, 24));
        endcase
        applyStimulus(v, 10'($urandom), 9'($urandom));
        checkModel($sformatf("rand_g%0d_k%0d", g, k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
